// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter - shares a 1-cycle-latency data memory between the core (port 0)
// and a loader port (port 1); fixed priority with a port 1 starvation guard.
// Optional: DMEM_ARB_PERF_EN enables grant/conflict performance counters.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [CNT_W-1:0]  perf_m0_cnt_o,
  output logic [CNT_W-1:0]  perf_m1_cnt_o,
  output logic [CNT_W-1:0]  perf_conflict_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       owner_q;
  logic       pend_q;
  logic       m1_win;

  // Port 1 wins when alone, or when it has been refused STARVE_LIMIT times.
  assign m1_win   = m1_req_i && (!m0_req_i || (starve_q == LIMIT));
  assign m1_gnt_o = m1_win;
  assign m0_gnt_o = m0_req_i && !m1_win;
  assign mem_req_o = m0_gnt_o | m1_gnt_o;

  assign mem_we_o    = m1_gnt_o ? m1_we_i    : m0_we_i;
  assign mem_be_o    = m1_gnt_o ? m1_be_i    : m0_be_i;
  assign mem_addr_o  = m1_gnt_o ? m1_addr_i  : m0_addr_i;
  assign mem_wdata_o = m1_gnt_o ? m1_wdata_i : m0_wdata_i;

  assign m0_rvalid_o = pend_q && !owner_q;
  assign m1_rvalid_o = pend_q &&  owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : 32'h0;

  always_comb begin
    starve_d = starve_q;
    if (m1_gnt_o) begin
      starve_d = 4'd0;
    end else if (m1_req_i && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
      owner_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= m1_gnt_o;
      pend_q   <= mem_req_o;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [CNT_W-1:0] perf_m0_q, perf_m1_q, perf_conf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_m0_q   <= '0;
      perf_m1_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      if (m0_gnt_o)             perf_m0_q   <= perf_m0_q + 1'b1;
      if (m1_gnt_o)             perf_m1_q   <= perf_m1_q + 1'b1;
      if (m0_req_i && m1_req_i) perf_conf_q <= perf_conf_q + 1'b1;
    end
  end

  assign perf_m0_cnt_o       = perf_m0_q;
  assign perf_m1_cnt_o       = perf_m1_q;
  assign perf_conflict_cnt_o = perf_conf_q;
`else
  assign perf_m0_cnt_o       = '0;
  assign perf_m1_cnt_o       = '0;
  assign perf_conflict_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter - directed and random stimulus against a reference model of
// the arbitration, response and counter rules, plus a behavioural memory.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LIMIT  = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]        m0_be_i, m1_be_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [31:0]       m0_wdata_i, m1_wdata_i;
  logic              m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0]       m0_rdata_o, m1_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o, mem_rdata_i;
  logic [CNT_W-1:0]  perf_m0_cnt_o, perf_m1_cnt_o, perf_conflict_cnt_o;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .perf_m0_cnt_o(perf_m0_cnt_o), .perf_m1_cnt_o(perf_m1_cnt_o),
    .perf_conflict_cnt_o(perf_conflict_cnt_o)
  );

  // Unwritten words hold a recognisable pattern so reads never return X.
  function automatic logic [31:0] init_word(input int idx);
    return (32'(idx) * 32'h01010101) ^ 32'hA5A5A5A5;
  endfunction

  // Behavioural single-port memory: read data one cycle after the strobe, 0 after a write.
  logic [31:0] mem [1024];
  bit          mem_wr [1024];
  always @(posedge clk) begin
    if (mem_req_o) begin
      logic [31:0] w;
      w = mem_wr[mem_addr_o[11:2]] ? mem[mem_addr_o[11:2]] : init_word(int'(mem_addr_o[11:2]));
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem[mem_addr_o[11:2]]    <= w;
        mem_wr[mem_addr_o[11:2]] <= 1'b1;
        mem_rdata_i              <= 32'h0;
      end else begin
        mem_rdata_i <= w;
      end
    end
  end

  // Reference model state
  int               refused;
  bit               e_pend, e_owner;
  logic [31:0]      e_data;
  logic [31:0]      ref_mem [1024];
  bit               ref_wr [1024];
  logic [CNT_W-1:0] c0, c1, cc;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set0(input bit r, input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    m0_req_i = r; m0_we_i = we; m0_be_i = be; m0_addr_i = a; m0_wdata_i = wd;
  endtask

  task automatic set1(input bit r, input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    m1_req_i = r; m1_we_i = we; m1_be_i = be; m1_addr_i = a; m1_wdata_i = wd;
  endtask

  task automatic idle();
    set0(0, 0, 4'h0, 32'h0, 32'h0);
    set1(0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic model_reset();
    refused = 0; e_pend = 0; e_owner = 0; e_data = 32'h0;
    c0 = '0; c1 = '0; cc = '0;
  endtask

  // Apply one access to the reference memory; returns the data the response carries.
  function automatic logic [31:0] ref_access(input bit we, input logic [3:0] be,
                                             input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    int idx;
    idx = int'(a[11:2]);
    w = ref_wr[idx] ? ref_mem[idx] : init_word(idx);
    if (!we) return w;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    ref_mem[idx] = w;
    ref_wr[idx]  = 1'b1;
    return 32'h0;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, {30'h0, m0_gnt_o, m1_gnt_o}, 32'h0);
    check({tag, "_rvalid"}, {30'h0, m0_rvalid_o, m1_rvalid_o}, 32'h0);
    check({tag, "_rdata"}, m0_rdata_o | m1_rdata_o, 32'h0);
    check({tag, "_perf"}, 32'(perf_m0_cnt_o | perf_m1_cnt_o | perf_conflict_cnt_o), 32'h0);
  endtask

  // One cycle: inputs already driven after a falling edge; check, clock, update model.
  task automatic tick(output bit g0, output bit g1);
    g1 = m1_req_i && (!m0_req_i || refused >= LIMIT);
    g0 = m0_req_i && !g1;
    #1;
    check("m0_gnt", 32'(m0_gnt_o), 32'(g0));
    check("m1_gnt", 32'(m1_gnt_o), 32'(g1));
    check("mem_req", 32'(mem_req_o), 32'(g0 | g1));
    check("mem_we", 32'(mem_we_o), 32'(g1 ? m1_we_i : m0_we_i));
    check("mem_be", 32'(mem_be_o), 32'(g1 ? m1_be_i : m0_be_i));
    check("mem_addr", mem_addr_o, g1 ? m1_addr_i : m0_addr_i);
    check("mem_wdata", mem_wdata_o, g1 ? m1_wdata_i : m0_wdata_i);
    check("m0_rvalid", 32'(m0_rvalid_o), 32'(e_pend && !e_owner));
    check("m1_rvalid", 32'(m1_rvalid_o), 32'(e_pend && e_owner));
    check("m0_rdata", m0_rdata_o, (e_pend && !e_owner) ? e_data : 32'h0);
    check("m1_rdata", m1_rdata_o, (e_pend && e_owner) ? e_data : 32'h0);
`ifdef DMEM_ARB_PERF_EN
    check("perf_m0", 32'(perf_m0_cnt_o), 32'(c0));
    check("perf_m1", 32'(perf_m1_cnt_o), 32'(c1));
    check("perf_conflict", 32'(perf_conflict_cnt_o), 32'(cc));
`else
    check("perf_off", 32'(perf_m0_cnt_o | perf_m1_cnt_o | perf_conflict_cnt_o), 32'h0);
`endif
    @(posedge clk);
    if (g1) refused = 0;
    else if (m1_req_i && refused < LIMIT) refused++;
    if (g0) c0++;
    if (g1) c1++;
    if (m0_req_i && m1_req_i) cc++;
    e_pend  = g0 | g1;
    e_owner = g1;
    if (g1)      e_data = ref_access(m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i);
    else if (g0) e_data = ref_access(m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i);
    @(negedge clk);
  endtask

  initial begin
    bit g0, g1, lg0, lg1;
    int m1_wins;
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Core write then read-back, loader idle
    set0(1, 1, 4'hF, 32'h200, 32'hDEADBEEF); tick(g0, g1);
    set0(1, 0, 4'hF, 32'h200, 32'h0);        tick(g0, g1);
    idle();
    #1 check("m0_readback", m0_rdata_o, 32'hDEADBEEF);
    tick(g0, g1);

    // Loader back-to-back reads
    set1(1, 0, 4'hF, 32'h200, 32'h0); tick(g0, g1);
    set1(1, 0, 4'hF, 32'h204, 32'h0); tick(g0, g1);
    set1(1, 0, 4'hF, 32'h208, 32'h0); tick(g0, g1);
    idle(); tick(g0, g1); tick(g0, g1);

    // Continuous conflict: expect 4:1
    m1_wins = 0;
    set0(1, 0, 4'hF, 32'h300, 32'h0);
    set1(1, 0, 4'hF, 32'h304, 32'h0);
    for (int i = 0; i < 15; i++) begin
      tick(g0, g1);
      if (g1) m1_wins++;
    end
    check("conflict_m1_wins", 32'(m1_wins), 32'd3);
    idle(); tick(g0, g1);

    // Port 0 then port 1 on consecutive cycles: no response crossover
    set0(1, 0, 4'hF, 32'h200, 32'h0); tick(g0, g1);
    set0(0, 0, 4'h0, 32'h0, 32'h0);
    set1(1, 0, 4'hF, 32'h204, 32'h0); tick(g0, g1);
    idle(); tick(g0, g1); tick(g0, g1);

    // Counter scenario from a clean reset
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    set0(1, 0, 4'hF, 32'h210, 32'h0);
    set1(1, 0, 4'hF, 32'h214, 32'h0);
    for (int i = 0; i < 10; i++) tick(g0, g1);
    set0(0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick(g0, g1);
    idle();
    #1;
`ifdef DMEM_ARB_PERF_EN
    check("perf_m0_total", 32'(perf_m0_cnt_o), 32'd8);
    check("perf_m1_total", 32'(perf_m1_cnt_o), 32'd5);
    check("perf_conflict_total", 32'(perf_conflict_cnt_o), 32'd10);
`else
    check("perf_total_off", 32'(perf_m0_cnt_o | perf_m1_cnt_o | perf_conflict_cnt_o), 32'h0);
`endif
    tick(g0, g1); tick(g0, g1);

    // Reset asserted while a port 1 read is in flight
    set1(1, 0, 4'hF, 32'h208, 32'h0);
    #1 check("rst_m1_gnt", 32'(m1_gnt_o), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    idle();
    #1 check_outputs_zero("rst_mid");
    @(negedge clk);
    check_outputs_zero("rst_hold");
    rst = 1'b0;
    model_reset();
    tick(g0, g1);
    set0(1, 0, 4'hF, 32'h200, 32'h0);
    tick(g0, g1);
    check("post_rst_m0_grant", 32'(g0), 32'd1);
    idle(); tick(g0, g1);

    // Random traffic; requesters hold their command until granted
    lg0 = 1; lg1 = 1;
    for (int i = 0; i < 400; i++) begin
      if (!m0_req_i || lg0) begin
        if ($urandom_range(0, 3) != 0)
          set0(1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
               32'h200 + 32'(4 * $urandom_range(0, 31)), $urandom);
        else
          set0(0, 0, 4'h0, 32'h0, 32'h0);
      end
      if (!m1_req_i || lg1) begin
        if ($urandom_range(0, 2) != 0)
          set1(1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
               32'h200 + 32'(4 * $urandom_range(0, 31)), $urandom);
        else
          set1(0, 0, 4'h0, 32'h0, 32'h0);
      end
      tick(lg0, lg1);
    end
    idle(); tick(g0, g1); tick(g0, g1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
